// File: rtl/key_search_ctrl.sv
// Brute-force key search sequencer: issues NCORES candidate indices per cycle,
// aligns delayed core results with their issued base and reports the first match.
module key_search_ctrl #(
  parameter int NCORES = 4,
  parameter int LAT    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  input  logic              Abort,
  input  logic [55:0]       limit,
  input  logic [NCORES-1:0] core_match,
  output logic              cand_valid,
  output logic [55:0]       cand_base,
  output logic [55:0]       count,
  output logic [63:0]       Key,
  output logic              Found,
  output logic              Exhausted,
  output logic              Busy
);

  localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [55:0]     r_base;
  logic [55:0]     r_limit;
  logic [55:0]     r_count;
  logic            r_found;
  logic            r_exh;
  logic [DW-1:0]   r_drain_cnt;
  logic [LAT-1:0]  r_dl_valid;
  logic [55:0]     r_dl_base [LAT];

  logic            w_start_go;
  logic            w_match;
  logic            w_drain_done;
  logic            w_last;
  logic            w_busy;
  logic            w_aligned_valid;
  logic [55:0]     w_aligned_base;
  logic [NCORES-1:0] w_qual;
  logic [55:0]     w_hit_off;
  logic [55:0]     w_hit_idx;
  logic [63:0]     w_key;

  assign w_aligned_valid = r_dl_valid[LAT-1];
  assign w_aligned_base  = r_dl_base[LAT-1];

  // 57-bit compares so a limit of 2^56-1 never wraps
  assign w_last = ({1'b0, r_base} + 57'(NCORES)) > {1'b0, r_limit};

  genvar gi;
  generate
    for (gi = 0; gi < NCORES; gi++) begin : g_qual
      assign w_qual[gi] = w_aligned_valid & core_match[gi] &
                          (({1'b0, w_aligned_base} + 57'(gi)) <= {1'b0, r_limit});
    end
  endgenerate

  // Descending scan leaves the lowest qualified core selected
  always_comb begin
    w_hit_off = '0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      if (w_qual[i]) begin
        w_hit_off = 56'(i);
      end
    end
  end

  assign w_hit_idx = w_aligned_base + w_hit_off;

  always_comb begin
    w_state_next = r_state;
    w_start_go   = 1'b0;
    w_match      = 1'b0;
    w_drain_done = 1'b0;
    if (Abort) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            w_state_next = S_SEARCH;
            w_start_go   = 1'b1;
          end
        end
        S_SEARCH: begin
          if (|w_qual) begin
            w_state_next = S_DONE;
            w_match      = 1'b1;
          end else if (w_last) begin
            w_state_next = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (|w_qual) begin
            w_state_next = S_DONE;
            w_match      = 1'b1;
          end else if (r_drain_cnt == '0) begin
            w_state_next = S_DONE;
            w_drain_done = 1'b1;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_limit     <= '0;
      r_count     <= '0;
      r_found     <= 1'b0;
      r_exh       <= 1'b0;
      r_drain_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (Abort) begin
        r_found <= 1'b0;
        r_exh   <= 1'b0;
        r_count <= '0;
      end else if (w_start_go) begin
        r_base  <= '0;
        r_limit <= limit;
        r_found <= 1'b0;
        r_exh   <= 1'b0;
        r_count <= '0;
      end else if (w_match) begin
        r_found <= 1'b1;
        r_count <= w_hit_idx;
      end else if (w_drain_done) begin
        r_exh   <= 1'b1;
        r_count <= r_limit + 56'd1;
      end else if (r_state == S_SEARCH) begin
        // Hold the base on the final group; the drain timer takes over
        if (w_last) begin
          r_drain_cnt <= DW'(LAT - 1);
        end else begin
          r_base <= r_base + 56'(NCORES);
        end
      end else if (r_state == S_DRAIN) begin
        r_drain_cnt <= r_drain_cnt - DW'(1);
      end
    end
  end

  // In-flight tracker: valids are flushed on reset, abort and every new search
  always_ff @(posedge clk) begin
    r_dl_base[0] <= r_base;
    for (int k = 1; k < LAT; k++) begin
      r_dl_base[k] <= r_dl_base[k-1];
    end
    if (reset || Abort || w_start_go) begin
      r_dl_valid <= '0;
    end else begin
      r_dl_valid[0] <= cand_valid;
      for (int k = 1; k < LAT; k++) begin
        r_dl_valid[k] <= r_dl_valid[k-1];
      end
    end
  end

  generate
    for (gi = 0; gi < 8; gi++) begin : g_key
      assign w_key[8*gi+7 -: 7] = r_count[7*gi +: 7];
      assign w_key[8*gi]        = ~^r_count[7*gi +: 7];
    end
  endgenerate

  assign w_busy     = (r_state == S_SEARCH) || (r_state == S_DRAIN);
  assign Busy       = w_busy;
  assign cand_valid = (r_state == S_SEARCH);
  assign cand_base  = r_base;
  assign count      = w_busy ? r_base : r_count;
  assign Found      = r_found;
  assign Exhausted  = r_exh;
  assign Key        = r_found ? w_key : 64'd0;

endmodule

// File: tb/tb_key_search_ctrl.sv
// Bench for key_search_ctrl: a cipher-core responder plays back matches for a
// chosen index set; outcomes are predicted from the search rules directly.
module tb_key_search_ctrl;

  localparam int NC = 4;
  localparam int LT = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          Start;
  logic          Abort;
  logic [55:0]   limit;
  logic [NC-1:0] core_match;
  logic          cand_valid;
  logic [55:0]   cand_base;
  logic [55:0]   count;
  logic [63:0]   Key;
  logic          Found;
  logic          Exhausted;
  logic          Busy;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [55:0] issued[$];
  logic        hv [LT+1];
  logic [55:0] hb [LT+1];
  logic [55:0] m_idx [3];
  int          m_n = 0;

  always #5 clk = ~clk;

  key_search_ctrl #(.NCORES(NC), .LAT(LT)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Abort(Abort), .limit(limit),
    .core_match(core_match), .cand_valid(cand_valid), .cand_base(cand_base),
    .count(count), .Key(Key), .Found(Found), .Exhausted(Exhausted), .Busy(Busy)
  );

  function automatic bit in_set(logic [55:0] x);
    for (int k = 0; k < m_n; k++) if (m_idx[k] == x) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] key_of(logic [55:0] v);
    logic [63:0] kk;
    logic [6:0]  b;
    kk = '0;
    for (int j = 0; j < 8; j++) begin
      b = v[7*j +: 7];
      kk[8*j+1 +: 7] = b;
      kk[8*j] = (($countones(b) % 2) == 0);
    end
    return kk;
  endfunction

  // Core farm model: whatever was issued comes back LT cycles later
  always @(negedge clk) begin
    if (cand_valid === 1'b1) issued.push_back(cand_base);
    for (int k = LT; k > 0; k--) begin
      hv[k] = hv[k-1];
      hb[k] = hb[k-1];
    end
    hv[0] = (cand_valid === 1'b1);
    hb[0] = cand_base;
    core_match = '0;
    if (hv[LT]) begin
      for (int i = 0; i < NC; i++) if (in_set(hb[LT] + 56'(i))) core_match[i] = 1'b1;
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (cand_valid !== 1'b0 || cand_base !== 56'd0 || count !== 56'd0 || Key !== 64'd0 ||
        Found !== 1'b0 || Exhausted !== 1'b0 || Busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: valid=%b base=%0d count=%0d key=%h F=%b E=%b B=%b, required all zero",
               cand_valid, cand_base, count, Key, Found, Exhausted, Busy);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_search(input string name, input logic [55:0] lim, input int n,
                            input logic [55:0] a, input logic [55:0] b, input logic [55:0] c,
                            input bit mid_start);
    bit          found;
    bit          both_seen;
    logic [63:0] best, g, last_grp, exp_groups;
    logic [55:0] exp_count;
    logic [63:0] exp_key;
    int          exp_c, cyc, bad;

    found = 1'b0;
    best  = '0;
    m_idx[0] = a; m_idx[1] = b; m_idx[2] = c;
    for (int k = 0; k < n; k++) begin
      if (m_idx[k] <= lim && (!found || {8'd0, m_idx[k]} < best)) begin
        found = 1'b1;
        best  = {8'd0, m_idx[k]};
      end
    end
    last_grp = {8'd0, lim} / 64'(NC);
    if (found) begin
      g          = best / 64'(NC);
      exp_c      = int'(g) + LT + 1;
      exp_groups = (g + 64'(LT + 1) < last_grp + 64'd1) ? g + 64'(LT + 1) : last_grp + 64'd1;
      exp_count  = best[55:0];
      exp_key    = key_of(best[55:0]);
    end else begin
      exp_c      = int'(last_grp) + LT + 1;
      exp_groups = last_grp + 64'd1;
      exp_count  = lim + 56'd1;
      exp_key    = 64'd0;
    end

    @(negedge clk);
    limit = lim;
    m_n   = n;
    issued.delete();
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    tests_run++;
    if (cand_valid !== 1'b1 || cand_base !== 56'd0 || count !== 56'd0 || Busy !== 1'b1 ||
        Found !== 1'b0 || Exhausted !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s first_cycle: valid=%b base=%0d count=%0d B=%b F=%b E=%b, required 1/0/0/1/0/0",
               name, cand_valid, cand_base, count, Busy, Found, Exhausted);
    end

    cyc = 0;
    both_seen = 1'b0;
    while (!(Found === 1'b1 || Exhausted === 1'b1) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      Start = mid_start && (cyc == 1);
      if (Found === 1'b1 && Exhausted === 1'b1) both_seen = 1'b1;
    end
    Start = 1'b0;

    tests_run++;
    if (cyc !== exp_c) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d cycles, required %0d", name, cyc, exp_c);
    end
    tests_run++;
    if (Found !== found || Exhausted !== !found || both_seen) begin
      tests_failed++;
      $display("FAIL %s flags: F=%b E=%b both=%b, required F=%b E=%b", name, Found, Exhausted,
               both_seen, found, !found);
    end
    tests_run++;
    if (count !== exp_count || Key !== exp_key || Busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s result: count=%0d key=%h busy=%b, required count=%0d key=%h busy=0",
               name, count, Key, Busy, exp_count, exp_key);
    end
    bad = 0;
    foreach (issued[k]) if (issued[k] !== 56'(NC * k)) bad++;
    tests_run++;
    if (64'(issued.size()) !== exp_groups || bad != 0) begin
      tests_failed++;
      $display("FAIL %s issue: %0d groups (%0d bad bases), required %0d groups stepping by %0d",
               name, issued.size(), bad, exp_groups, NC);
    end

    repeat (3) @(negedge clk);
    tests_run++;
    if (64'(issued.size()) !== exp_groups || cand_valid !== 1'b0 || Found !== found ||
        Exhausted !== !found || count !== exp_count) begin
      tests_failed++;
      $display("FAIL %s hold: groups=%0d valid=%b F=%b E=%b count=%0d, required groups=%0d valid=0 F=%b E=%b count=%0d",
               name, issued.size(), cand_valid, Found, Exhausted, count, exp_groups, found, !found, exp_count);
    end
  endtask

  task automatic test_directed();
    run_search("match_idx10", 56'd100, 1, 56'd10, 56'd0, 56'd0, 1'b0);
    tests_run++;
    if (Key !== 64'h0101010101010115) begin
      tests_failed++;
      $display("FAIL key_idx10: got %h, required 0101010101010115", Key);
    end
    run_search("exhaust_lim9", 56'd9, 0, 56'd0, 56'd0, 56'd0, 1'b0);
    run_search("over_limit_ignored", 56'd9, 1, 56'd11, 56'd0, 56'd0, 1'b0);
    run_search("lowest_wins", 56'd100, 2, 56'd7, 56'd5, 56'd0, 1'b0);
    run_search("limit_zero", 56'd0, 0, 56'd0, 56'd0, 56'd0, 1'b0);
    run_search("limit_three", 56'd3, 1, 56'd4, 56'd0, 56'd0, 1'b0);
    run_search("limit_four", 56'd4, 1, 56'd4, 56'd0, 56'd0, 1'b0);
    run_search("limit_max", 56'hFF_FFFF_FFFF_FFFF, 1, 56'd6, 56'd0, 56'd0, 1'b1);
  endtask

  task automatic test_abort();
    bit bad;
    @(negedge clk);
    limit = 56'd100; m_n = 1; m_idx[0] = 56'd0;
    Start = 1'b1; Abort = 1'b1;
    @(negedge clk);
    Start = 1'b0; Abort = 1'b0;
    tests_run++;
    if (Busy !== 1'b0 || cand_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_beats_start: busy=%b valid=%b, required 0/0", Busy, cand_valid);
    end
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    @(negedge clk);
    Abort = 1'b1;
    @(negedge clk);
    Abort = 1'b0;
    bad = 1'b0;
    repeat (5) begin
      if (Found !== 1'b0 || Exhausted !== 1'b0 || Busy !== 1'b0 || cand_valid !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL abort_idle: F=%b E=%b busy=%b valid=%b, required all 0 after abort",
               Found, Exhausted, Busy, cand_valid);
    end
    run_search("restart_after_abort", 56'd100, 1, 56'd0, 56'd0, 56'd0, 1'b0);
  endtask

  task automatic test_reset_in_drain();
    bit bad;
    @(negedge clk);
    limit = 56'd9; m_n = 1; m_idx[0] = 56'd9;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (Busy !== 1'b1 || cand_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_state: busy=%b valid=%b, required 1/0", Busy, cand_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if (cand_valid !== 1'b0 || cand_base !== 56'd0 || count !== 56'd0 || Key !== 64'd0 ||
        Found !== 1'b0 || Exhausted !== 1'b0 || Busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_in_drain: valid=%b base=%0d count=%0d key=%h F=%b E=%b B=%b, required all zero",
               cand_valid, cand_base, count, Key, Found, Exhausted, Busy);
    end
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (Found !== 1'b0 || Exhausted !== 1'b0 || Busy !== 1'b0) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL post_reset_match: F=%b E=%b busy=%b, required 0/0/0", Found, Exhausted, Busy);
    end
  endtask

  task automatic test_random();
    logic [55:0] lim, a, b, c;
    int n;
    bit ms;
    for (int it = 0; it < 12; it++) begin
      lim = 56'($urandom_range(0, 120));
      n   = int'($urandom_range(0, 3));
      a   = 56'($urandom_range(0, 130));
      b   = 56'($urandom_range(0, 130));
      c   = 56'($urandom_range(0, 130));
      ms  = 1'($urandom_range(0, 1));
      run_search($sformatf("rand%0d", it), lim, n, a, b, c, ms);
    end
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; Abort = 1'b0; limit = '0; core_match = '0;
    for (int k = 0; k <= LT; k++) begin
      hv[k] = 1'b0;
      hb[k] = '0;
    end
    test_reset();
    test_directed();
    test_abort();
    test_reset_in_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/key_search_ctrl.md
KEY_SEARCH_CTRL -- requirements
Module: key_search_ctrl

Interface
REQ-001 Parameter NCORES, default 4, number of parallel cipher cores fed per cycle; SHALL be a power of two, 1..64.
REQ-002 Parameter LAT, default 16, fixed core pipeline latency in cycles from cand_valid to core_match; SHALL be at least 1.
REQ-003 clk  in  1  single clock; all logic SHALL be rising-edge clocked.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 Start  in  1  single-cycle pulse that begins a search.
REQ-006 Abort  in  1  cancels the search; wins over Start.
REQ-007 limit  in  56  highest candidate index to test, inclusive; sampled on the Start cycle.
REQ-008 core_match  in  NCORES  bit i high means candidate cand_base+i issued LAT cycles earlier matched.
REQ-009 cand_valid  out  1  a candidate group is issued this cycle.
REQ-010 cand_base  out  56  index of core 0's candidate; core i tests cand_base+i.
REQ-011 count  out  56  current base while searching; matching index once Found; limit+1 once Exhausted.
REQ-012 Key  out  64  DES key of the matching index; zero unless Found.
REQ-013 Found  out  1  match located, held until Start, Abort or reset.
REQ-014 Exhausted  out  1  range fully tested without a match, held like Found.
REQ-015 Busy  out  1  high in SEARCH and DRAIN.

Function
REQ-016 FSM states SHALL be IDLE, SEARCH, DRAIN and DONE.
REQ-017 IDLE or DONE with Start=1 and Abort=0 SHALL go to SEARCH next cycle, clearing Found, Exhausted and the in-flight tracker; cand_base SHALL be 0 on the first SEARCH cycle.
REQ-018 SEARCH: cand_valid=1 every cycle and cand_base SHALL advance by NCORES per cycle.
REQ-019 When the issued group satisfies cand_base+NCORES > limit, that group SHALL be the last issued; the next state SHALL be DRAIN.
REQ-020 The cand_base+NCORES comparison SHALL be computed in 57 bits, so limit=2^56-1 never wraps.
REQ-021 A LAT-deep delay line of {valid, base} SHALL align each core_match sample with its issued base.
REQ-022 core_match bits SHALL be ignored when the aligned valid bit is 0, or when base+i > limit.
REQ-023 Among simultaneous qualified bits, the lowest index i SHALL win.
REQ-024 The first qualified match, in SEARCH or DRAIN, SHALL move the FSM to DONE with Found=1 on the next cycle, count=base+i.
REQ-025 After a match, issue SHALL stop and later results SHALL be discarded.
REQ-026 DRAIN: LAT cycles after the last issue with no qualified match, the FSM SHALL go to DONE with Exhausted=1 and count=limit+1 (truncated to 56 bits).
REQ-027 Key mapping: for byte j=0..7, Key[8j+7:8j+1]=count[7j+6:7j], and Key[8j] SHALL be the odd-parity bit of those 7 bits.
REQ-028 Abort=1 in any state SHALL go to IDLE next cycle: in-flight valids cleared, cand_valid=0, Found=0, Exhausted=0.
REQ-029 Start while Busy SHALL be ignored.
REQ-030 Found and Exhausted SHALL never be high together.

Reset
REQ-031 reset=1 SHALL force, next cycle: state IDLE, cand_valid=0, cand_base=0, count=0, Key=0, Found=0, Exhausted=0, Busy=0, all delay-line valids 0.
REQ-032 reset mid-search SHALL discard all in-flight results; core_match SHALL be ignored until a new Start.

Verification (NCORES=4, LAT=3)
REQ-033 Start, limit=100, core_match[2] on the cycle aligned with base 8 -> Found=1 one cycle later, count=10, Key=64'h0101010101010115, cand_valid low after that.
REQ-034 limit=9, no matches -> bases 0,4,8 issued, then DRAIN for 3 cycles -> Exhausted=1, count=10, Found=0.
REQ-035 limit=9, core_match[3] aligned with base 8 (index 11) -> ignored, Exhausted=1.
REQ-036 core_match=4'b1010 aligned with base 4 -> Found, count=5 (lowest index wins).
REQ-037 Abort two cycles after Start, then a match on the next cycle -> IDLE, Found=0, Busy=0; a later Start restarts at cand_base=0.
REQ-038 reset during DRAIN -> all outputs at reset values next cycle; a following aligned core_match has no effect.
